// File: rtl/board_cursor_ctrl.sv
// Push-button front end for the board: synchronise, debounce and edge-detect five keys,
// then step a wrapping or saturating cursor, with an optional ship-length clamp on the column.
module board_cursor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BOARD_SIZE      = 5,
  parameter int WRAP            = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       key_left_n,
  input  logic       key_right_n,
  input  logic       key_confirm_n,
  input  logic       enable,
  input  logic       place_mode,
  input  logic [2:0] ship_len,
  output logic [2:0] i_actual,
  output logic [2:0] j_actual,
  output logic       confirm_level,
  output logic       confirm_pulse
);

  localparam int              CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LP_CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      LP_SIZE   = 4'(BOARD_SIZE);
  localparam logic [3:0]      LP_MAX    = 4'(BOARD_SIZE - 1);

  // Key order in all 5-bit vectors: {confirm, right, left, down, up}
  logic [4:0] w_keys;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] w_deb;
  logic [4:0] r_deb_q;

  assign w_keys = ~{key_confirm_n, key_right_n, key_left_n, key_down_n, key_up_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_keys;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 5; g++) begin : g_deb
    logic [CNT_W-1:0] r_cnt;
    logic             r_state;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt   <= '0;
        r_state <= 1'b0;
      end else if (r_sync2[g] == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_CNT_TC) begin
        r_state <= r_sync2[g];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_deb[g] = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb_q <= '0;
    end else begin
      r_deb_q <= w_deb;
    end
  end

  logic [3:0] w_rise;
  logic       w_up;
  logic       w_down;
  logic       w_left;
  logic       w_right;
  logic       w_conf_fall;

  assign w_rise      = w_deb[3:0] & ~r_deb_q[3:0];
  assign w_up        = w_rise[0] & enable;
  assign w_down      = w_rise[1] & enable;
  assign w_left      = w_rise[2] & enable;
  assign w_right     = w_rise[3] & enable;
  assign w_conf_fall = r_deb_q[4] & ~w_deb[4];

  logic [2:0] r_i;
  logic [2:0] r_j;
  logic       r_pulse;
  logic [3:0] w_i4;
  logic [3:0] w_j4;
  logic [3:0] w_len;
  logic [3:0] w_jmax;
  logic [2:0] w_i_nxt;
  logic [2:0] w_j_nxt;

  assign w_i4 = {1'b0, r_i};
  assign w_j4 = {1'b0, r_j};

  // Effective ship length, clipped into 1..BOARD_SIZE
  always_comb begin
    w_len = {1'b0, ship_len};
    if (ship_len == 3'd0) begin
      w_len = 4'd1;
    end else if (w_len > LP_SIZE) begin
      w_len = LP_SIZE;
    end
  end

  assign w_jmax = place_mode ? (LP_SIZE - w_len) : LP_MAX;

  always_comb begin
    w_i_nxt = r_i;
    if (w_up && !w_down) begin
      if (w_i4 == 4'd0) begin
        w_i_nxt = (WRAP != 0) ? 3'(LP_MAX) : 3'd0;
      end else begin
        w_i_nxt = 3'(w_i4 - 4'd1);
      end
    end else if (w_down && !w_up) begin
      if (w_i4 >= LP_MAX) begin
        w_i_nxt = (WRAP != 0) ? 3'd0 : r_i;
      end else begin
        w_i_nxt = 3'(w_i4 + 4'd1);
      end
    end
  end

  // Column moves use jmax as the right edge; an out-of-range column snaps back first.
  always_comb begin
    w_j_nxt = r_j;
    if (w_left && !w_right) begin
      if (w_j4 == 4'd0) begin
        w_j_nxt = (WRAP != 0) ? 3'(w_jmax) : 3'd0;
      end else begin
        w_j_nxt = 3'(w_j4 - 4'd1);
      end
    end else if (w_right && !w_left) begin
      if (w_j4 >= w_jmax) begin
        w_j_nxt = (WRAP != 0) ? 3'd0 : 3'(w_jmax);
      end else begin
        w_j_nxt = 3'(w_j4 + 4'd1);
      end
    end
    if (place_mode && (w_j4 > w_jmax)) begin
      w_j_nxt = 3'(w_jmax);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i     <= 3'd0;
      r_j     <= 3'd0;
      r_pulse <= 1'b0;
    end else begin
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_pulse <= w_conf_fall & enable;
    end
  end

  assign i_actual      = r_i;
  assign j_actual      = r_j;
  assign confirm_level = r_deb_q[4];
  assign confirm_pulse = r_pulse;

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// Directed bench for board_cursor_ctrl with short debounce; a second instance runs with WRAP=0.
module tb_board_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] r_keys_n = 5'b11111;   // {confirm, right, left, down, up}
  logic       enable = 1'b1;
  logic       place_mode = 1'b0;
  logic [2:0] ship_len = 3'd0;

  logic [2:0] i_w, j_w, i_s, j_s;
  logic       lvl_w, pls_w, lvl_s, pls_s;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int K_UP = 0, K_DOWN = 1, K_LEFT = 2, K_RIGHT = 3, K_CONF = 4;

  always #5 clk = ~clk;

  board_cursor_ctrl #(.DEBOUNCE_CYCLES(4), .BOARD_SIZE(5), .WRAP(1)) dut (
    .clk(clk), .rst(rst),
    .key_up_n(r_keys_n[0]), .key_down_n(r_keys_n[1]), .key_left_n(r_keys_n[2]),
    .key_right_n(r_keys_n[3]), .key_confirm_n(r_keys_n[4]),
    .enable(enable), .place_mode(place_mode), .ship_len(ship_len),
    .i_actual(i_w), .j_actual(j_w), .confirm_level(lvl_w), .confirm_pulse(pls_w)
  );

  board_cursor_ctrl #(.DEBOUNCE_CYCLES(4), .BOARD_SIZE(5), .WRAP(0)) dut_sat (
    .clk(clk), .rst(rst),
    .key_up_n(r_keys_n[0]), .key_down_n(r_keys_n[1]), .key_left_n(r_keys_n[2]),
    .key_right_n(r_keys_n[3]), .key_confirm_n(r_keys_n[4]),
    .enable(enable), .place_mode(place_mode), .ship_len(ship_len),
    .i_actual(i_s), .j_actual(j_s), .confirm_level(lvl_s), .confirm_pulse(pls_s)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Hold one key low for 'hold' edges, then release and let the debouncer settle.
  task automatic press(input int k, input int hold);
    r_keys_n[k] = 1'b0;
    tick(hold);
    r_keys_n[k] = 1'b1;
    tick(12);
  endtask

  task automatic confirm_run(input string tag, input int exp_pulses);
    int lvl_cnt, pls_cnt, first_lvl, pls_at;
    lvl_cnt = 0; pls_cnt = 0; first_lvl = -1; pls_at = -1;
    r_keys_n[K_CONF] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (lvl_w) begin
        lvl_cnt++;
        if (first_lvl < 0) first_lvl = k;
      end
      if (pls_w) begin
        pls_cnt++;
        pls_at = k;
      end
      if (k == 10) r_keys_n[K_CONF] = 1'b1;
    end
    chk({tag, "_level_cycles"}, lvl_cnt, 10);
    chk({tag, "_level_rise"}, first_lvl, 7);
    chk({tag, "_pulses"}, pls_cnt, exp_pulses);
    if (exp_pulses == 1) chk({tag, "_pulse_time"}, pls_at, 17);
  endtask

  initial begin
    do_reset();
    chk("rst_i", i_w, 0);
    chk("rst_j", j_w, 0);
    chk("rst_level", lvl_w, 0);
    chk("rst_pulse", pls_w, 0);

    // 1: single step, 7-edge latency, no auto-repeat
    r_keys_n[K_RIGHT] = 1'b0;
    tick(6);
    chk("t1_j_before", j_w, 0);
    tick(1);
    chk("t1_j_at7", j_w, 1);
    tick(13);
    chk("t1_j_held", j_w, 1);
    r_keys_n[K_RIGHT] = 1'b1;
    tick(10);
    chk("t1_j_after", j_w, 1);
    chk("t1_i", i_w, 0);

    // 2: glitch rejected, real press accepted
    press(K_DOWN, 3);
    chk("t2_glitch_i", i_w, 0);
    press(K_DOWN, 10);
    chk("t2_press_i", i_w, 1);

    // 3: wrap vs saturate on i
    do_reset();
    press(K_UP, 10);
    chk("t3_wrap_up", i_w, 4);
    chk("t3_sat_up", i_s, 0);
    press(K_DOWN, 10);
    chk("t3_wrap_down", i_w, 0);
    chk("t3_sat_down", i_s, 1);

    // 4: placement clamp
    do_reset();
    for (int n = 0; n < 4; n++) press(K_RIGHT, 10);
    chk("t4_j_edge", j_w, 4);
    place_mode = 1'b1;
    ship_len = 3'd3;
    tick(1);
    chk("t4_clamp", j_w, 2);
    chk("t4_clamp_sat", j_s, 2);
    press(K_RIGHT, 10);
    chk("t4_wrap_jmax", j_w, 0);
    chk("t4_sat_jmax", j_s, 2);
    ship_len = 3'd0;
    press(K_LEFT, 10);
    chk("t4_len0_wrap", j_w, 4);
    chk("t4_len0_sat", j_s, 1);
    place_mode = 1'b0;

    // 5: confirm level and pulse, enabled then disabled
    do_reset();
    enable = 1'b1;
    confirm_run("t5_en", 1);
    tick(5);
    enable = 1'b0;
    confirm_run("t5_dis", 0);
    enable = 1'b1;
    tick(5);

    // 6: enable gating, simultaneous keys, reset mid-debounce
    do_reset();
    press(K_RIGHT, 10);
    press(K_RIGHT, 10);
    chk("t6_j_start", j_w, 2);
    enable = 1'b0;
    press(K_RIGHT, 10);
    enable = 1'b1;
    tick(5);
    chk("t6_disabled_j", j_w, 2);
    r_keys_n[K_LEFT] = 1'b0;
    r_keys_n[K_RIGHT] = 1'b0;
    r_keys_n[K_DOWN] = 1'b0;
    tick(10);
    r_keys_n = 5'b11111;
    tick(12);
    chk("t6_lr_j", j_w, 2);
    chk("t6_down_i", i_w, 1);

    r_keys_n[K_UP] = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_i", i_w, 0);
    chk("t6_rst_j", j_w, 0);
    chk("t6_rst_level", lvl_w, 0);
    rst = 1'b0;
    r_keys_n[K_UP] = 1'b1;
    tick(10);
    press(K_RIGHT, 3);
    chk("t6_short_j", j_w, 0);
    chk("t6_short_i", i_w, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
